// File: rtl/line_length_if.sv
// line_length_if: sample stream in (din/en) and line-length result out (dout).
interface line_length_if #(parameter int data_width = 31);
    logic [data_width:0] din;
    logic                en;
    logic [data_width:0] dout;
    modport master (output din, en, input dout);
    modport slave  (input din, en, output dout);
endinterface

// File: rtl/line_length.sv
// line_length: sliding-window sum of |x[n]-x[n-1]| over WIN_LEN samples.
// LINELENGTH_NORM_EN selects the window mean instead of the saturated raw sum.
module line_length #(
    parameter int data_width = 31,
    parameter int WIN_LEN    = 256
) (
    input logic        clk,
    input logic        rst,
    line_length_if.slave io
);
    localparam int AW = $clog2(WIN_LEN);
    localparam int SW = data_width + 1 + AW;
    localparam logic [data_width-1:0] AD_MAX = '1;
    logic [data_width:0]   prev_q, dout_q, dout_d;
    logic [data_width-1:0] mem_q [WIN_LEN];
    logic [AW-1:0]         ptr_q;
    logic                  first_q;
    logic [SW-1:0]         sum_q, sum_d;
    logic signed [data_width+1:0] diff;
    logic [data_width+1:0] mag;
    logic [data_width-1:0] ad_d;
    always_comb begin
        diff  = $signed({io.din[data_width], io.din}) - $signed({prev_q[data_width], prev_q});
        mag   = diff[data_width+1] ? $unsigned(-diff) : $unsigned(diff);
        ad_d  = first_q ? '0 : (|mag[data_width+1:data_width]) ? AD_MAX : mag[data_width-1:0];
        // the evicted entry is already part of sum_q, so this never underflows
        sum_d = sum_q + SW'(ad_d) - SW'(mem_q[ptr_q]);
`ifdef LINELENGTH_NORM_EN
        dout_d = (data_width+1)'(sum_d >> AW);
`else
        dout_d = (sum_d > SW'(AD_MAX)) ? {1'b0, AD_MAX} : sum_d[data_width:0];
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= '0;
            dout_q  <= '0;
            sum_q   <= '0;
            ptr_q   <= '0;
            first_q <= 1'b1;
            for (int i = 0; i < WIN_LEN; i++) mem_q[i] <= '0;
        end else if (io.en) begin
            prev_q       <= io.din;
            dout_q       <= dout_d;
            sum_q        <= sum_d;
            mem_q[ptr_q] <= ad_d;
            ptr_q        <= ptr_q + AW'(1);
            first_q      <= 1'b0;
        end
    end
    assign io.dout = dout_q;
endmodule

// File: tb/tb_line_length.sv
// tb_line_length: randomized scoreboard bench for line_length against a window model.
module tb_line_length;
    localparam int DW = 31;
    localparam int WIN = 4;
    localparam longint MAXV = (longint'(1) << DW) - 1;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;
    line_length_if #(.data_width(DW)) io ();
    line_length #(.data_width(DW), .WIN_LEN(WIN)) dut (.clk(clk), .rst(rst), .io(io));
    int total = 0;
    int bad = 0;
    longint exp_q[$];
    longint ads[$];
    longint prev_s, last_exp;
    bit first_s = 1;
    function automatic void check(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, req, $time);
        end
    endfunction
    function automatic void model_reset();
        ads.delete();
        first_s  = 1;
        last_exp = 0;
    endfunction
    // mean/sum of the last WIN clamped absolute differences since reset
    function automatic longint model_sample(longint d);
        longint ad, s;
        ad = first_s ? 0 : (d > prev_s ? d - prev_s : prev_s - d);
        if (ad > MAXV) ad = MAXV;
        first_s = 0;
        prev_s  = d;
        ads.push_back(ad);
        if (ads.size() > WIN) void'(ads.pop_front());
        s = 0;
        foreach (ads[i]) s += ads[i];
`ifdef LINELENGTH_NORM_EN
        s = s / WIN;
`else
        if (s > MAXV) s = MAXV;
`endif
        return s;
    endfunction
    task automatic cyc(input bit r, input bit e, input logic [31:0] d);
        @(negedge clk);
        rst    = r;
        io.en  = e;
        io.din = d;
        if (!r) model_reset();
        else if (e) last_exp = model_sample(longint'($signed(d)));
        exp_q.push_back(last_exp);
    endtask
    function automatic logic [31:0] pick();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
    endfunction
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("dout", longint'(io.dout), exp_q.pop_front());
    end
    initial begin
        logic [31:0] alt [6];
        alt = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'd100, 32'd100};
        io.en  = 0;
        io.din = 0;
        repeat (5) cyc(0, 1, pick());
        cyc(1, 1, pick());
        cyc(0, 0, 0);
        repeat (10) cyc(1, 1, 32'd1234);
        cyc(0, 0, 0);
        foreach (alt[i]) cyc(1, 1, alt[i]);
        repeat (5) cyc(1, 1, pick());
        repeat (3) cyc(1, 0, pick());
        repeat (5) cyc(1, 1, pick());
        cyc(0, 0, 0);
        repeat (6) begin
            cyc(1, 1, 32'h8000_0000);
            cyc(1, 1, 32'h7fff_ffff);
        end
        repeat (6) cyc(1, 1, pick());
        @(posedge clk);
        #3 rst = 0;
        #1 check("async_rst", longint'(io.dout), 0);
        model_reset();
        repeat (5) cyc(0, 1, pick());
        cyc(1, 1, pick());
        repeat (300) cyc($urandom_range(0, 40) != 0, $urandom_range(0, 3) != 0, pick());
        @(posedge clk);
        #2 check("drain", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
